// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory read at
// a time and hands fetched words to decode over a valid/ready handshake.
// Redirects from the branch ALU reload the PC and squash wrong-path fetches.
//
// Build option: define FETCH_SKID_EN to turn the output slot into a 2-entry
// FIFO so fetch keeps streaming across a single decode stall. Without it the
// output is a single register and the next request waits for it to drain.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// FETCH  | request pending or about to be issued at pc
// WAIT   | request accepted, waiting for read data (dropped if squash set)
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_redirect,
   input  logic [31:0] i_redirectPC,
   output logic        o_memReq,
   output logic [31:0] o_memAddr,
   input  logic        i_memAck,
   input  logic        i_memValid,
   input  logic [31:0] i_memData,
   output logic        o_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_instPC,
   input  logic        i_ready
);

`ifdef FETCH_SKID_EN
   localparam logic [1:0] DEPTH = 2'd2;
`else
   localparam logic [1:0] DEPTH = 2'd1;
`endif
   localparam logic [31:0] STEP = 32'(PC_STEP);

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_WAIT  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        squash_q, squash_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] head_inst_q, head_inst_d;
   logic [31:0] head_pc_q, head_pc_d;
`ifdef FETCH_SKID_EN
   logic [31:0] tail_inst_q, tail_inst_d;
   logic [31:0] tail_pc_q, tail_pc_d;
`endif

   logic        mem_req;
   logic        pop;
   logic        push;
   logic [1:0]  cnt_left;

   // Next-state, request generation, redirect handling and output slot update.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      squash_d    = squash_q;
      cnt_d       = cnt_q;
      head_inst_d = head_inst_q;
      head_pc_d   = head_pc_q;
`ifdef FETCH_SKID_EN
      tail_inst_d = tail_inst_q;
      tail_pc_d   = tail_pc_q;
`endif
      mem_req  = 1'b0;
      push     = 1'b0;
      pop      = (cnt_q != 2'd0) && i_ready;
      cnt_left = cnt_q - {1'b0, pop};

      if (state_q == ST_FETCH) begin
         // Gated by reset so the request stays low while reset is held.
         mem_req = i_reset && (cnt_left < DEPTH);
         if (mem_req && i_memAck) begin
            state_d  = ST_WAIT;
            req_pc_d = pc_q;
         end
      end else begin
         if (i_memValid) begin
            state_d = ST_FETCH;
            if (squash_q) begin
               squash_d = 1'b0;
            end else begin
               push = 1'b1;
               pc_d = req_pc_q + STEP;
            end
         end
      end

      // Redirect overrides everything except a transfer already in progress.
      if (i_redirect) begin
         pc_d = i_redirectPC;
         push = 1'b0;
         if (state_q == ST_WAIT) begin
            if (i_memValid) begin
               state_d  = ST_FETCH;
               squash_d = 1'b0;
            end else begin
               squash_d = 1'b1;
            end
         end else if (mem_req && i_memAck) begin
            squash_d = 1'b1;
         end
      end

`ifdef FETCH_SKID_EN
      if (pop) begin
         head_inst_d = tail_inst_q;
         head_pc_d   = tail_pc_q;
      end
`endif
      if (push) begin
         if (cnt_left == 2'd0) begin
            head_inst_d = i_memData;
            head_pc_d   = req_pc_q;
         end
`ifdef FETCH_SKID_EN
         else begin
            tail_inst_d = i_memData;
            tail_pc_d   = req_pc_q;
         end
`endif
      end

      cnt_d = i_redirect ? 2'd0 : (cnt_left + {1'b0, push});
   end

   // State and datapath registers.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         req_pc_q    <= RESET_PC;
         squash_q    <= 1'b0;
         cnt_q       <= 2'd0;
         head_inst_q <= 32'h0;
         head_pc_q   <= 32'h0;
`ifdef FETCH_SKID_EN
         tail_inst_q <= 32'h0;
         tail_pc_q   <= 32'h0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         squash_q    <= squash_d;
         cnt_q       <= cnt_d;
         head_inst_q <= head_inst_d;
         head_pc_q   <= head_pc_d;
`ifdef FETCH_SKID_EN
         tail_inst_q <= tail_inst_d;
         tail_pc_q   <= tail_pc_d;
`endif
      end
   end

   assign o_memReq  = mem_req;
   assign o_memAddr = pc_q;
   assign o_valid   = (cnt_q != 2'd0);
   assign o_inst    = head_inst_q;
   assign o_instPC  = head_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle-exact vector table, directed stall and
// mid-WAIT reset sequences, then randomized traffic against a stream model
// (each delivered word must be the successor of the last, or the redirect
// target, and carry the memory image for its address).
module tb_fetch_stage;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirectPC = 32'h0;
   logic        o_memReq;
   logic [31:0] o_memAddr;
   logic        i_memAck = 1'b0;
   logic        i_memValid = 1'b0;
   logic [31:0] i_memData = 32'h0;
   logic        o_valid;
   logic [31:0] o_inst;
   logic [31:0] o_instPC;
   logic        i_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   fetch_stage dut (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_redirect   (i_redirect),
      .i_redirectPC (i_redirectPC),
      .o_memReq     (o_memReq),
      .o_memAddr    (o_memAddr),
      .i_memAck     (i_memAck),
      .i_memValid   (i_memValid),
      .i_memData    (i_memData),
      .o_valid      (o_valid),
      .o_inst       (o_inst),
      .o_instPC     (o_instPC),
      .i_ready      (i_ready)
   );

   always #5 i_clock = ~i_clock;

   // Memory image: every address holds a word derived from the address.
   function automatic logic [31:0] dat(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rdy, input logic red, input logic [31:0] rpc,
                        input logic ack, input logic mv, input logic [31:0] md);
      @(negedge i_clock);
      i_ready      = rdy;
      i_redirect   = red;
      i_redirectPC = rpc;
      i_memAck     = ack;
      i_memValid   = mv;
      i_memData    = md;
      #1;
   endtask

   task automatic do_reset();
      i_reset      = 1'b0;
      i_ready      = 1'b0;
      i_redirect   = 1'b0;
      i_redirectPC = 32'h0;
      i_memAck     = 1'b0;
      i_memValid   = 1'b0;
      i_memData    = 32'h0;
      repeat (2) @(negedge i_clock);
      #1;
      chk("reset o_valid", o_valid, 0);
      chk("reset o_memReq", o_memReq, 0);
      chk("reset o_inst", o_inst, 0);
      chk("reset o_instPC", o_instPC, 0);
      @(negedge i_clock);
      i_reset = 1'b1;
   endtask

   typedef struct {
      logic        rdy;
      logic        red;
      logic [31:0] rpc;
      logic        ack;
      logic        mv;
      logic [31:0] md_addr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   localparam int NV = 26;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic rdy, input logic red, input logic [31:0] rpc,
                               input logic ack, input logic mv, input logic [31:0] md_addr,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pc);
      vec_t v;
      v.rdy = rdy; v.red = red; v.rpc = rpc; v.ack = ack; v.mv = mv;
      v.md_addr = md_addr; v.e_req = e_req; v.e_addr = e_addr;
      v.e_valid = e_valid; v.e_pc = e_pc;
      return v;
   endfunction

   logic [31:0] exp_pc;
   logic        mem_busy;
   logic [31:0] mem_addr;
   int          mem_cnt;
   int          xfers;
   logic        prev_hold, prev_req_hold;
   logic [31:0] prev_pc, prev_inst, prev_addr;

   initial begin
      //            rdy red rpc           ack mv  md_addr       req addr          vld pc
      tbl[0]  = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         0, 32'h0);
      tbl[1]  = mk(1, 0, 32'h0,         0, 1, 32'h0,         0, 32'h0,         0, 32'h0);
      tbl[2]  = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h4,         1, 32'h0);
      tbl[3]  = mk(1, 0, 32'h0,         0, 1, 32'h4,         0, 32'h0,         0, 32'h0);
      tbl[4]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         1, 32'h4);
      tbl[5]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         0, 32'h0);
      tbl[6]  = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h8,         0, 32'h0);
      tbl[7]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
      tbl[8]  = mk(1, 1, 32'h100,       0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
      tbl[9]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
      tbl[10] = mk(1, 0, 32'h0,         0, 1, 32'h8,         0, 32'h0,         0, 32'h0);
      tbl[11] = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       0, 32'h0);
      tbl[12] = mk(1, 0, 32'h0,         0, 1, 32'h100,       0, 32'h0,         0, 32'h0);
      tbl[13] = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h104,       1, 32'h100);
      tbl[14] = mk(1, 1, 32'hFFFF_FFFC, 0, 1, 32'h104,       0, 32'h0,         0, 32'h0);
      tbl[15] = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0);
      tbl[16] = mk(1, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0);
      tbl[17] = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFFC);
      tbl[18] = mk(1, 0, 32'h0,         0, 1, 32'h0,         0, 32'h0,         0, 32'h0);
      tbl[19] = mk(1, 1, 32'h200,       0, 0, 32'h0,         1, 32'h4,         1, 32'h0);
      tbl[20] = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h200,       0, 32'h0);
      tbl[21] = mk(1, 0, 32'h0,         0, 1, 32'h200,       0, 32'h0,         0, 32'h0);
      tbl[22] = mk(1, 1, 32'h300,       1, 0, 32'h0,         1, 32'h204,       1, 32'h200);
      tbl[23] = mk(1, 0, 32'h0,         0, 1, 32'h204,       0, 32'h0,         0, 32'h0);
      tbl[24] = mk(1, 0, 32'h0,         0, 1, 32'hDEAD0,     1, 32'h300,       0, 32'h0);
      tbl[25] = mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h300,       0, 32'h0);

      // Cycle-exact vectors: streaming, hold-until-ack, redirect cases, wrap.
      do_reset();
      for (int k = 0; k < NV; k++) begin
         drive(tbl[k].rdy, tbl[k].red, tbl[k].rpc, tbl[k].ack, tbl[k].mv, dat(tbl[k].md_addr));
         chk($sformatf("vec%0d req", k), o_memReq, tbl[k].e_req);
         if (tbl[k].e_req) chk($sformatf("vec%0d addr", k), o_memAddr, tbl[k].e_addr);
         chk($sformatf("vec%0d valid", k), o_valid, tbl[k].e_valid);
         if (tbl[k].e_valid) begin
            chk($sformatf("vec%0d instPC", k), o_instPC, tbl[k].e_pc);
            chk($sformatf("vec%0d inst", k), o_inst, dat(tbl[k].e_pc));
         end
      end

      // Decode stall of 5 cycles with a word waiting.
      do_reset();
      drive(0, 0, 32'h0, 1, 0, 32'h0);
      chk("stall first req", o_memReq, 1);
      drive(0, 0, 32'h0, 0, 1, dat(32'h0));
      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 32'h0, 0, 0, 32'h0);
         chk("stall valid", o_valid, 1);
         chk("stall instPC", o_instPC, 32'h0);
         chk("stall inst", o_inst, dat(32'h0));
`ifndef FETCH_SKID_EN
         chk("stall no req", o_memReq, 0);
`endif
      end
      drive(1, 0, 32'h0, 1, 0, 32'h0);
      chk("resume valid", o_valid, 1);
      chk("resume instPC", o_instPC, 32'h0);
      chk("resume req", o_memReq, 1);
      chk("resume addr", o_memAddr, 32'h4);
      drive(1, 0, 32'h0, 0, 1, dat(32'h4));
      drive(1, 0, 32'h0, 0, 0, 32'h0);
      chk("resume next valid", o_valid, 1);
      chk("resume next instPC", o_instPC, 32'h4);

      // Reset asserted while a request is outstanding.
      do_reset();
      drive(1, 0, 32'h0, 1, 0, 32'h0);
      drive(1, 0, 32'h0, 0, 1, dat(32'h0));
      drive(1, 0, 32'h0, 1, 0, 32'h0);
      chk("pre-reset instPC", o_instPC, 32'h0);
      drive(1, 0, 32'h0, 0, 0, 32'h0);
      #2 i_reset = 1'b0;
      #1;
      chk("midwait reset req", o_memReq, 0);
      chk("midwait reset valid", o_valid, 0);
      chk("midwait reset inst", o_inst, 0);
      chk("midwait reset instPC", o_instPC, 0);
      @(negedge i_clock);
      i_reset = 1'b1;
      drive(1, 0, 32'h0, 0, 1, dat(32'h4));
      chk("late valid req", o_memReq, 1);
      chk("late valid addr", o_memAddr, 32'h0);
      chk("late valid o_valid", o_valid, 0);
      drive(1, 0, 32'h0, 1, 0, 32'h0);
      chk("restart o_valid", o_valid, 0);
      chk("restart addr", o_memAddr, 32'h0);
      drive(1, 0, 32'h0, 0, 1, dat(32'h0));
      drive(1, 0, 32'h0, 0, 0, 32'h0);
      chk("restart first valid", o_valid, 1);
      chk("restart first instPC", o_instPC, 32'h0);

      // Randomized traffic against the stream model.
      do_reset();
      exp_pc        = 32'h0;
      mem_busy      = 1'b0;
      mem_addr      = 32'h0;
      mem_cnt       = 0;
      xfers         = 0;
      prev_hold     = 1'b0;
      prev_req_hold = 1'b0;
      prev_pc       = 32'h0;
      prev_inst     = 32'h0;
      prev_addr     = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge i_clock);
         i_ready      = ($urandom_range(0, 3) != 0);
         i_redirect   = ($urandom_range(0, 19) == 0);
         i_redirectPC = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
         i_memAck     = 1'b0;
         if (mem_busy && mem_cnt == 0) begin
            i_memValid = 1'b1;
            i_memData  = dat(mem_addr);
            mem_busy   = 1'b0;
         end else begin
            i_memValid = 1'b0;
            i_memData  = $urandom;
            if (mem_busy) mem_cnt--;
         end
         #1;
         if (prev_hold) begin
            chk("rand hold valid", o_valid, 1);
            chk("rand hold instPC", o_instPC, prev_pc);
            chk("rand hold inst", o_inst, prev_inst);
         end
         if (prev_req_hold) begin
            chk("rand req held", o_memReq, 1);
            chk("rand addr held", o_memAddr, prev_addr);
         end
`ifndef FETCH_SKID_EN
         if (o_valid && !i_ready) chk("rand no req while stalled", o_memReq, 0);
`endif
         if (o_memReq && $urandom_range(0, 2) != 0) begin
            i_memAck = 1'b1;
            chk("rand one outstanding", mem_busy, 0);
            mem_busy = 1'b1;
            mem_addr = o_memAddr;
            mem_cnt  = $urandom_range(0, 2);
         end
         if (o_valid && i_ready) begin
            chk("rand stream instPC", o_instPC, exp_pc);
            chk("rand stream inst", o_inst, dat(exp_pc));
            exp_pc = exp_pc + 32'd4;
            xfers++;
         end
         if (i_redirect) exp_pc = i_redirectPC;
         prev_hold     = o_valid && !i_ready && !i_redirect;
         prev_pc       = o_instPC;
         prev_inst     = o_inst;
         prev_req_hold = o_memReq && !i_memAck && !i_redirect;
         prev_addr     = o_memAddr;
      end
      chk("rand progress", (xfers >= 100), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
